// File: rtl/axi_lite_pkg.sv
// Shared widths, response codes and FSM state types for the AXI-Lite register slave.
package axi_lite_pkg;

  localparam int AXI_ADDR_W = 64;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_STRB_W = 8;

  typedef enum logic {
    RESP_OKAY   = 1'b0,
    RESP_SLVERR = 1'b1
  } resp_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI-Lite bus bundle (AW, W, B, AR, R channels) with master and slave views.
interface axi_lite_reg_slave_if;
  import axi_lite_pkg::*;

  logic [AXI_ADDR_W-1:0] awaddr;
  logic                  awvalid;
  logic [AXI_ID_W-1:0]   awid;
  logic [2:0]            awprot;
  logic                  awready;

  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_STRB_W-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  logic                  bvalid;
  logic                  bresp;
  logic                  bready;

  logic [AXI_ADDR_W-1:0] araddr;
  logic [AXI_ID_W-1:0]   arid;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [AXI_DATA_W-1:0] rdata;
  logic [AXI_ID_W-1:0]   rid;
  logic                  rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, awid, awprot, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bvalid, bresp, output bready,
    output araddr, arid, arprot, arvalid, input arready,
    input rdata, rid, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, awid, awprot, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bvalid, bresp, input bready,
    input araddr, arid, arprot, arvalid, output arready,
    output rdata, rid, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_regbank.sv
// Register array with one byte-strobed write port and one combinational read port.
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [AXI_DATA_W-1:0] wdata,
  input  logic [AXI_STRB_W-1:0] wstrb,
  input  logic [IDX_W-1:0]      ridx,
  output logic [AXI_DATA_W-1:0] rdata
);

  logic [AXI_DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < AXI_STRB_W; b++) begin
        if (wstrb[b]) begin
          regs[widx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Reads see the value before any same-edge write lands.
  assign rdata = regs[ridx];

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave exposing NUM_REGS 64-bit registers; independent read and write FSMs.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int                    NUM_REGS  = 16,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                 aclk,
  input  logic                 arst,
  axi_lite_reg_slave_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REGS);

  wstate_e wstate, wstate_next;
  rstate_e rstate, rstate_next;

  logic                  ready_en;
  logic                  aw_held, w_held;
  logic [AXI_ADDR_W-1:0] aw_addr_q;
  logic [AXI_DATA_W-1:0] w_data_q;
  logic [AXI_STRB_W-1:0] w_strb_q;
  logic                  bvalid_q;
  resp_e                 bresp_q;
  logic                  rvalid_q;
  resp_e                 rresp_q;
  logic [AXI_DATA_W-1:0] rdata_q;
  logic [AXI_ID_W-1:0]   rid_q;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [AXI_ADDR_W-1:0] wr_addr, wr_off, rd_off;
  logic [AXI_DATA_W-1:0] wr_data, bank_rdata;
  logic [AXI_STRB_W-1:0] wr_strb;
  logic                  wr_borrow, rd_borrow, wr_in_range, rd_in_range;
  logic                  unused_inputs;

  assign unused_inputs = ^{bus.awid, bus.awprot, bus.arprot};

  // ready_en keeps every ready low until the first edge after reset release.
  assign bus.awready = ready_en && (wstate == W_IDLE) && !aw_held;
  assign bus.wready  = ready_en && (wstate == W_IDLE) && !w_held;
  assign bus.arready = ready_en && (rstate == R_IDLE);
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;
  assign bus.rid     = rid_q;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign b_hs  = bvalid_q && bus.bready;
  assign ar_hs = bus.arvalid && bus.arready;
  assign r_hs  = rvalid_q && bus.rready;

  assign wr_addr = aw_held ? aw_addr_q : bus.awaddr;
  assign wr_data = w_held ? w_data_q : bus.wdata;
  assign wr_strb = w_held ? w_strb_q : bus.wstrb;

  // Borrow-based decode avoids overflow of BASE_ADDR + 8*NUM_REGS.
  assign {wr_borrow, wr_off} = {1'b0, wr_addr} - {1'b0, BASE_ADDR};
  assign {rd_borrow, rd_off} = {1'b0, bus.araddr} - {1'b0, BASE_ADDR};
  assign wr_in_range = !wr_borrow && ((wr_off >> 3) < 64'(NUM_REGS));
  assign rd_in_range = !rd_borrow && ((rd_off >> 3) < 64'(NUM_REGS));

  axi_lite_regbank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regbank (
    .clk   (aclk),
    .rst_n (arst),
    .we    (commit && wr_in_range),
    .widx  (wr_off[IDX_W+2:3]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .ridx  (rd_off[IDX_W+2:3]),
    .rdata (bank_rdata)
  );

  always_comb begin
    wstate_next = wstate;
    commit      = 1'b0;
    case (wstate)
      W_IDLE: begin
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          wstate_next = W_RESP;
          commit      = 1'b1;
        end
      end
      W_RESP: begin
        if (b_hs) wstate_next = W_IDLE;
      end
      default: wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      wstate    <= W_IDLE;
      ready_en  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate   <= wstate_next;
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= bus.awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= bus.wdata;
        w_strb_q <= bus.wstrb;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
    end
  end

  always_comb begin
    rstate_next = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_next = R_DATA;
      R_DATA:  if (r_hs) rstate_next = R_IDLE;
      default: rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      rstate   <= R_IDLE;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      rid_q    <= '0;
    end else begin
      rstate <= rstate_next;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        rdata_q  <= rd_in_range ? bank_rdata : '0;
        rid_q    <= bus.arid;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed self-checking bench for axi_lite_reg_slave (NUM_REGS=16, BASE_ADDR=0).
module tb_axi_lite_reg_slave;

  logic aclk;
  logic arst;
  int   checks;
  int   failures;

  logic [63:0] rd;
  logic [3:0]  rid;
  logic        rsp;
  logic        wrsp;

  axi_lite_reg_slave_if bus ();

  axi_lite_reg_slave #(
    .NUM_REGS  (16),
    .BASE_ADDR (64'h0)
  ) dut (
    .aclk (aclk),
    .arst (arst),
    .bus  (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyWrite(input string tag, input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, output logic resp);
    bit aw_hs, w_hs, aw_done, w_done;
    int n;
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b0;
    aw_done = 0;
    w_done  = 0;
    n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge aclk); #1;
      if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.wvalid = 1'b0;  end
      n++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    checkOutput({tag, "_accept"}, 64'(aw_done && w_done), 64'd1);
    checkOutput({tag, "_lat"}, 64'(bus.bvalid), 64'd1);
    n = 0;
    while (!bus.bvalid && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic applyRead(input string tag, input logic [63:0] addr, input logic [3:0] id,
                           output logic [63:0] data, output logic [3:0] id_out, output logic resp);
    bit ar_hs, ar_done;
    int n;
    bus.araddr  = addr;
    bus.arid    = id;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    ar_done = 0;
    n = 0;
    while (!ar_done && n < 20) begin
      ar_hs = bus.arvalid && bus.arready;
      @(posedge aclk); #1;
      if (ar_hs) ar_done = 1;
      n++;
    end
    bus.arvalid = 1'b0;
    checkOutput({tag, "_rvalid"}, 64'(bus.rvalid), 64'd1);
    n = 0;
    while (!bus.rvalid && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    data   = bus.rdata;
    id_out = bus.rid;
    resp   = bus.rresp;
    bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.rready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.awaddr = '0; bus.awvalid = 0; bus.awid = '0; bus.awprot = '0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
    bus.araddr = '0; bus.arid = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 0;

    arst = 1'b1;
    #2 arst = 1'b0;
    #1;
    checkOutput("rst_awready", 64'(bus.awready), 64'd0);
    checkOutput("rst_wready", 64'(bus.wready), 64'd0);
    checkOutput("rst_arready", 64'(bus.arready), 64'd0);
    checkOutput("rst_bvalid", 64'(bus.bvalid), 64'd0);
    checkOutput("rst_rvalid", 64'(bus.rvalid), 64'd0);
    checkOutput("rst_rdata", bus.rdata, 64'd0);
    repeat (2) @(posedge aclk);
    #3 arst = 1'b1;
    #1;
    checkOutput("rel_awready_pre", 64'(bus.awready), 64'd0);
    @(posedge aclk); #1;
    checkOutput("rel_awready", 64'(bus.awready), 64'd1);
    checkOutput("rel_wready", 64'(bus.wready), 64'd1);
    checkOutput("rel_arready", 64'(bus.arready), 64'd1);

    $display("[TB] same-cycle write and readback");
    applyWrite("wr_same", 64'h08, 64'hDEAD_BEEF_0123_4567, 8'hFF, wrsp);
    checkOutput("wr_same_bresp", 64'(wrsp), 64'd0);
    applyRead("rd_same", 64'h08, 4'h3, rd, rid, rsp);
    checkOutput("rd_same_data", rd, 64'hDEAD_BEEF_0123_4567);
    checkOutput("rd_same_rid", 64'(rid), 64'd3);
    checkOutput("rd_same_rresp", 64'(rsp), 64'd0);

    $display("[TB] W three cycles before AW");
    bus.awaddr = 64'h10; bus.wdata = 64'h1111_2222_3333_4444; bus.wstrb = 8'hFF;
    bus.wvalid = 1'b1; bus.awvalid = 1'b0;
    @(posedge aclk); #1;
    bus.wvalid = 1'b0;
    checkOutput("wfirst_wready", 64'(bus.wready), 64'd0);
    checkOutput("wfirst_awready", 64'(bus.awready), 64'd1);
    repeat (2) begin
      @(posedge aclk); #1;
      checkOutput("wfirst_wready_hold", 64'(bus.wready), 64'd0);
      checkOutput("wfirst_no_b", 64'(bus.bvalid), 64'd0);
    end
    bus.awvalid = 1'b1;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    checkOutput("wfirst_lat", 64'(bus.bvalid), 64'd1);
    checkOutput("wfirst_bresp", 64'(bus.bresp), 64'd0);
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    checkOutput("wfirst_bclr", 64'(bus.bvalid), 64'd0);
    applyRead("rd_wfirst", 64'h10, 4'h1, rd, rid, rsp);
    checkOutput("rd_wfirst_data", rd, 64'h1111_2222_3333_4444);

    $display("[TB] partial strobes");
    applyWrite("wr_ones", 64'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, wrsp);
    applyWrite("wr_low", 64'h08, 64'h0, 8'h0F, wrsp);
    applyRead("rd_strb", 64'h08, 4'h2, rd, rid, rsp);
    checkOutput("rd_strb_data", rd, 64'hFFFF_FFFF_0000_0000);
    applyWrite("wr_nostrb", 64'h08, 64'h0, 8'h00, wrsp);
    checkOutput("wr_nostrb_bresp", 64'(wrsp), 64'd0);
    applyRead("rd_lowbits", 64'h0F, 4'h7, rd, rid, rsp);
    checkOutput("rd_lowbits_data", rd, 64'hFFFF_FFFF_0000_0000);
    checkOutput("rd_lowbits_rid", 64'(rid), 64'd7);

    $display("[TB] address range boundaries");
    applyWrite("wr_r0", 64'h00, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, wrsp);
    applyWrite("wr_r15", 64'h78, 64'h7777_0000_7777_0000, 8'hFF, wrsp);
    checkOutput("wr_r15_bresp", 64'(wrsp), 64'd0);
    applyWrite("wr_oor", 64'h80, 64'h1234_5678_9ABC_DEF0, 8'hFF, wrsp);
    checkOutput("wr_oor_bresp", 64'(wrsp), 64'd1);
    applyRead("rd_oor", 64'h80, 4'h4, rd, rid, rsp);
    checkOutput("rd_oor_data", rd, 64'd0);
    checkOutput("rd_oor_rresp", 64'(rsp), 64'd1);
    applyRead("rd_r0", 64'h00, 4'h0, rd, rid, rsp);
    checkOutput("rd_r0_data", rd, 64'hA5A5_A5A5_5A5A_5A5A);
    applyRead("rd_r15", 64'h78, 4'hF, rd, rid, rsp);
    checkOutput("rd_r15_data", rd, 64'h7777_0000_7777_0000);
    checkOutput("rd_r15_rresp", 64'(rsp), 64'd0);

    $display("[TB] stalled responses with same-edge read of written register");
    bus.awaddr = 64'h18; bus.wdata = 64'h0BAD_CAFE_F00D_0001; bus.wstrb = 8'hFF;
    bus.araddr = 64'h18; bus.arid = 4'h5;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    checkOutput("stall_bresp", 64'(bus.bresp), 64'd0);
    checkOutput("stall_rresp", 64'(bus.rresp), 64'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_bvalid", 64'(bus.bvalid), 64'd1);
      checkOutput("stall_rvalid", 64'(bus.rvalid), 64'd1);
      checkOutput("stall_rdata", bus.rdata, 64'd0);
      checkOutput("stall_rid", 64'(bus.rid), 64'd5);
      checkOutput("stall_awready", 64'(bus.awready), 64'd0);
      checkOutput("stall_wready", 64'(bus.wready), 64'd0);
      checkOutput("stall_arready", 64'(bus.arready), 64'd0);
      @(posedge aclk); #1;
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    checkOutput("stall_bclr", 64'(bus.bvalid), 64'd0);
    checkOutput("stall_rclr", 64'(bus.rvalid), 64'd0);
    checkOutput("stall_arready_back", 64'(bus.arready), 64'd1);
    applyRead("rd_after_stall", 64'h18, 4'h6, rd, rid, rsp);
    checkOutput("rd_after_stall_data", rd, 64'h0BAD_CAFE_F00D_0001);

    $display("[TB] reset during W_RESP and R_DATA");
    bus.awaddr = 64'h100; bus.wdata = 64'hFFFF_0000_FFFF_0000; bus.wstrb = 8'hFF;
    bus.araddr = 64'h08; bus.arid = 4'h9;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    checkOutput("pre_rst_bresp", 64'(bus.bresp), 64'd1);
    checkOutput("pre_rst_rdata", bus.rdata, 64'hFFFF_FFFF_0000_0000);
    #2 arst = 1'b0;
    #1;
    checkOutput("mid_rst_awready", 64'(bus.awready), 64'd0);
    checkOutput("mid_rst_wready", 64'(bus.wready), 64'd0);
    checkOutput("mid_rst_arready", 64'(bus.arready), 64'd0);
    checkOutput("mid_rst_bvalid", 64'(bus.bvalid), 64'd0);
    checkOutput("mid_rst_bresp", 64'(bus.bresp), 64'd0);
    checkOutput("mid_rst_rvalid", 64'(bus.rvalid), 64'd0);
    checkOutput("mid_rst_rresp", 64'(bus.rresp), 64'd0);
    checkOutput("mid_rst_rdata", bus.rdata, 64'd0);
    checkOutput("mid_rst_rid", 64'(bus.rid), 64'd0);
    @(posedge aclk);
    #3 arst = 1'b1;
    @(posedge aclk); #1;
    checkOutput("post_rst_awready", 64'(bus.awready), 64'd1);
    checkOutput("post_rst_wready", 64'(bus.wready), 64'd1);
    checkOutput("post_rst_arready", 64'(bus.arready), 64'd1);
    checkOutput("post_rst_bvalid", 64'(bus.bvalid), 64'd0);
    applyRead("rd_post_rst1", 64'h08, 4'h1, rd, rid, rsp);
    checkOutput("rd_post_rst1_data", rd, 64'd0);
    applyRead("rd_post_rst3", 64'h18, 4'h2, rd, rid, rsp);
    checkOutput("rd_post_rst3_data", rd, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
